ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- Upstream stage of game_FSM. Receives PS/2 keyboard frames and drives the `tasta[7:0]` scan-code bus and its `done` strobe, which the game FSM samples only inside `active_zone`.
- Decodes set-2 make codes, suppresses break (key-release) sequences, flags the E0 extended prefix, and stretches `done` so it is seen across VGA blanking.
- Runs entirely in the 25 MHz system/pixel clock domain. PS/2 lines are treated as asynchronous inputs.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples needed before a PS/2 line level is accepted (glitch filter).
- TIMEOUT_CYCLES, 5000: system clocks with no PS/2 falling edge mid-frame before the frame is aborted (200 us at 25 MHz).
- DONE_HOLD, 40000: system clocks `done` stays high after a valid make code. Must exceed vertical blanking (45 lines x 800 clocks = 36000).

Ports:
- `clock`  in  1  system clock, 25 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the keyboard, asynchronous.
- `tasta`  out  8  last accepted make code; held until the next one.
- `done`  out  1  high for DONE_HOLD clocks after each accepted make code.
- `ext_key`  out  1  1 if the current `tasta` code was preceded by E0; same timing as `tasta`.
- `frame_err`  out  1  one-clock pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset (`reset`=0, any time, including mid-frame) sets:
  - `tasta`=0, `done`=0, `ext_key`=0, `frame_err`=0.
  - Bit counter 0, shift register 0, break_pending=0, ext_pending=0, state IDLE.
  - Filter outputs =1 (idle-high lines).
- Input conditioning:
  - 2-FF synchronizer on each PS/2 line, then the FILTER_LEN glitch filter.
  - A falling edge is filtered clk going 1->0.
  - Data is sampled from filtered data in the same cycle the falling edge is detected.
- Frame: 11 bits = start(0), D0..D7 LSB first, odd parity, stop(1).
- State machine:
  - IDLE: on falling edge, if data=0 go to DATA (bit count 0); if data=1 stay in IDLE with no error (spurious start).
  - DATA: shift the sampled bit into `sh[7:0]` from the MSB side (so D0 lands at bit 0 after 8 shifts). After the 8th bit go to PARITY.
  - PARITY: latch the sampled parity bit, then go to STOP.
  - STOP: on falling edge, the frame is valid if stop=1 and XOR(`sh`, parity)=1.
    - Valid: go to DECODE for one clock.
    - Invalid: pulse `frame_err`, discard the byte, go to IDLE.
  - Timeout: in DATA, PARITY or STOP, if TIMEOUT_CYCLES elapse since the last falling edge, pulse `frame_err` and go to IDLE. The timeout counter clears on every falling edge.
  - DECODE, one clock, then IDLE:
    - `sh`=F0: break_pending=1. No output.
    - `sh`=E0: ext_pending=1. No output.
    - Other code with break_pending=1: suppressed; clear break_pending and ext_pending.
    - Other code with break_pending=0: `tasta`<=`sh`, `ext_key`<=ext_pending, clear ext_pending, `done`<=1, hold counter<=DONE_HOLD-1.
- `done` timing:
  - Goes high the clock after DECODE.
  - Counts down while high and drops the clock after the counter reaches 0, i.e. exactly DONE_HOLD cycles high.
  - A new accepted code while `done` is high updates `tasta` and `ext_key` and restarts the hold. `done` stays high with no low gap.
- Typematic repeats of a held key are ordinary make codes and are each reported.
- Overall latency: the stop-bit falling edge plus 2 clocks to `done` rising, excluding synchronizer/filter delay (2+FILTER_LEN clocks).
- Error cases do not alter `tasta`, `done`, break_pending or ext_pending.
- Two consecutive F0 bytes: break_pending stays 1, so only the next non-F0/E0 code is suppressed.

Test Plan:
- Send make 0x1C (A) with parity 0 and stop 1 -> `tasta`=0x1C, `done`=1 for exactly 40000 clocks, `ext_key`=0, `frame_err` never pulses.
- Send F0 then 0x1C -> `tasta` and `done` unchanged from their prior values; break_pending clears; then send 0x29 -> `tasta`=0x29, `done` rises.
- Send E0 then 0x75 -> `tasta`=0x75, `ext_key`=1; then send 0x16 -> `tasta`=0x16, `ext_key`=0.
- Send 0x23 with wrong parity (1) -> one-clock `frame_err`, `tasta` unchanged. Repeat with stop=0 -> same response.
- Stop `ps2_clk` after 5 bits for 6000 clocks -> `frame_err` pulses at 5000 clocks after the last edge, FSM in IDLE; the next full 0x4B frame is then decoded correctly.
- Send 0x1C, then 0x23 at 20000 clocks into the hold -> `done` stays continuously high for 60000 clocks total, `tasta`=0x23. Assert `reset` mid-frame -> all outputs 0 and the next frame decodes normally.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, deframes 11-bit
// frames, decodes set-2 make codes and presents them on tasta with a
// stretched done strobe long enough to survive VGA vertical blanking.

// One PS/2 line: 2-FF synchronizer followed by a consecutive-sample glitch filter.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DONE_HOLD      = 40000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tasta,
    output logic       done,
    output logic       ext_key,
    output logic       frame_err
);
    localparam int NUM_LINES = 2;
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W    = $clog2(DONE_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DECODE
    } state_t;

    logic [NUM_LINES-1:0] raw;
    logic [NUM_LINES-1:0] filt;
    logic                 clk_f;
    logic                 data_f;
    logic                 clk_q;
    logic                 fall;

    state_t               state;
    logic [2:0]           bit_cnt;
    logic [7:0]           sh;
    logic                 par;
    logic [TMO_W-1:0]     tmo;
    logic                 tmo_exp;
    logic                 break_pending;
    logic                 ext_pending;
    logic [HOLD_W-1:0]    hold;

    assign raw = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            ps2_line_filter #(
                .FILTER_LEN(FILTER_LEN)
            ) u_filt (
                .clock(clock),
                .reset(reset),
                .raw  (raw[gi]),
                .filt (filt[gi])
            );
        end
    endgenerate

    assign clk_f   = filt[0];
    assign data_f  = filt[1];
    assign fall    = clk_q & ~clk_f;
    assign tmo_exp = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    // Deframing FSM, decode of prefixes and the done hold timer, all registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_q         <= 1'b1;
            state         <= S_IDLE;
            bit_cnt       <= '0;
            sh            <= '0;
            par           <= 1'b0;
            tmo           <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            tasta         <= '0;
            ext_key       <= 1'b0;
            done          <= 1'b0;
            hold          <= '0;
            frame_err     <= 1'b0;
        end else begin
            clk_q     <= clk_f;
            frame_err <= 1'b0;

            // Hold countdown; a new accept in DECODE below overrides it.
            if (done) begin
                if (hold == '0) done <= 1'b0;
                else            hold <= hold - 1'b1;
            end

            // Mid-frame inactivity timer, restarted by every falling edge.
            if (fall)
                tmo <= '0;
            else if (state == S_DATA || state == S_PARITY || state == S_STOP)
                tmo <= tmo + 1'b1;

            case (state)
                S_IDLE: begin
                    // A falling edge with data high is a spurious start: ignore it.
                    if (fall && !data_f) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (fall) begin
                        sh      <= {data_f, sh[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end else if (tmo_exp) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_PARITY: begin
                    if (fall) begin
                        par   <= data_f;
                        state <= S_STOP;
                    end else if (tmo_exp) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        if (data_f && (^sh ^ par)) begin
                            state <= S_DECODE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else if (tmo_exp) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DECODE: begin
                    state <= S_IDLE;
                    if (sh == 8'hF0) begin
                        break_pending <= 1'b1;
                    end else if (sh == 8'hE0) begin
                        ext_pending <= 1'b1;
                    end else if (break_pending) begin
                        // Key release: swallow the code and forget any E0 seen.
                        break_pending <= 1'b0;
                        ext_pending   <= 1'b0;
                    end else begin
                        tasta       <= sh;
                        ext_key     <= ext_pending;
                        ext_pending <= 1'b0;
                        done        <= 1'b1;
                        hold        <= HOLD_W'(DONE_HOLD - 1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx, run with shortened timing parameters
// so every scenario (including full hold windows) fits in a short run.
module tb_ps2_keyboard_rx;
    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int DH   = 800;
    localparam int HALF = 20;
    localparam int LAT  = FL + 4;  // stop-bit drive to done visible at negedge

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] tasta;
    logic       done;
    logic       ext_key;
    logic       frame_err;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int   rise_cnt = 0, rise_cyc = 0, run = 0, last_len = 0;
    int   err_pulse = 0, err_cycles = 0, err_cyc = 0;
    logic done_d = 1'b0, err_d = 1'b0;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO),
        .DONE_HOLD     (DH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .tasta    (tasta),
        .done     (done),
        .ext_key  (ext_key),
        .frame_err(frame_err)
    );

    always #20 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observe done runs and frame_err pulses away from the active edge.
    always @(negedge clock) begin
        if (done && !done_d) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
            run      <= 1;
        end else if (done) begin
            run <= run + 1;
        end
        if (!done && done_d) last_len <= run;
        if (frame_err) begin
            err_cycles <= err_cycles + 1;
            if (!err_d) begin
                err_pulse <= err_pulse + 1;
                err_cyc   <= cyc;
            end
        end
        done_d <= done;
        err_d  <= frame_err;
    end

    // Drive up to nbits of a frame; t_last is the cycle of the last falling edge.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop, input int nbits, output int t_last);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ par_flip, b, 1'b0};
        t_last = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            t_last = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        send_frame(b, 1'b0, 1'b1, 11, t);
    endtask

    task automatic wait_done_low(input string name);
        int k;
        k = 0;
        while (done && k < 3 * DH) begin
            @(negedge clock);
            k++;
        end
        repeat (2) @(negedge clock);
        n_total++;
        if (done !== 1'b0) $display("FAIL %s: done still %b after %0d cycles, want 0", name, done, k);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        n_total++; if (tasta !== 8'h00) $display("FAIL reset_tasta: got %h want 00", tasta); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (ext_key !== 1'b0) $display("FAIL reset_ext: got %b want 0", ext_key); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err); else n_pass++;
        reset = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_make;
        int t;
        send_frame(8'h1C, 1'b0, 1'b1, 11, t);
        n_total++; if (tasta !== 8'h1C) $display("FAIL make_tasta: got %h want 1c", tasta); else n_pass++;
        n_total++; if (ext_key !== 1'b0) $display("FAIL make_ext: got %b want 0", ext_key); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL make_done: got %b want 1", done); else n_pass++;
        n_total++; if (rise_cyc !== t + LAT) $display("FAIL make_latency: rise at %0d want %0d", rise_cyc, t + LAT); else n_pass++;
        wait_done_low("make_done_fall");
        n_total++; if (last_len !== DH) $display("FAIL make_hold_len: got %0d want %0d", last_len, DH); else n_pass++;
        n_total++; if (err_pulse !== 0) $display("FAIL make_no_err: got %0d pulses want 0", err_pulse); else n_pass++;
    endtask

    task automatic test_break;
        int r0;
        r0 = rise_cnt;
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_total++; if (tasta !== 8'h1C || done !== 1'b0) $display("FAIL break_suppress: tasta %h done %b want 1c/0", tasta, done); else n_pass++;
        send_byte(8'hF0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_total++; if (rise_cnt !== r0 || done !== 1'b0) $display("FAIL double_f0_suppress: rises %0d done %b want %0d/0", rise_cnt, done, r0); else n_pass++;
        send_byte(8'h29);
        n_total++; if (tasta !== 8'h29) $display("FAIL break_next_tasta: got %h want 29", tasta); else n_pass++;
        n_total++; if (rise_cnt !== r0 + 1) $display("FAIL break_next_rise: got %0d want %0d", rise_cnt, r0 + 1); else n_pass++;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_total++; if (tasta !== 8'h29 || ext_key !== 1'b0) $display("FAIL ext_break_suppress: tasta %h ext %b want 29/0", tasta, ext_key); else n_pass++;
    endtask

    task automatic test_ext;
        send_byte(8'hE0);
        send_byte(8'h75);
        n_total++; if (tasta !== 8'h75) $display("FAIL ext_tasta: got %h want 75", tasta); else n_pass++;
        n_total++; if (ext_key !== 1'b1) $display("FAIL ext_flag: got %b want 1", ext_key); else n_pass++;
        send_byte(8'h16);
        n_total++; if (tasta !== 8'h16) $display("FAIL ext_next_tasta: got %h want 16", tasta); else n_pass++;
        n_total++; if (ext_key !== 1'b0) $display("FAIL ext_next_flag: got %b want 0", ext_key); else n_pass++;
    endtask

    task automatic test_errors;
        int p0, c0, t;
        p0 = err_pulse;
        c0 = err_cycles;
        send_frame(8'h23, 1'b1, 1'b1, 11, t);
        n_total++; if (err_pulse !== p0 + 1 || err_cycles !== c0 + 1) $display("FAIL parity_err: pulses %0d cycles %0d want %0d/%0d", err_pulse, err_cycles, p0 + 1, c0 + 1); else n_pass++;
        n_total++; if (tasta !== 8'h16 || ext_key !== 1'b0) $display("FAIL parity_keep: tasta %h ext %b want 16/0", tasta, ext_key); else n_pass++;
        send_frame(8'h23, 1'b0, 1'b0, 11, t);
        n_total++; if (err_pulse !== p0 + 2 || err_cycles !== c0 + 2) $display("FAIL stop_err: pulses %0d cycles %0d want %0d/%0d", err_pulse, err_cycles, p0 + 2, c0 + 2); else n_pass++;
        n_total++; if (tasta !== 8'h16) $display("FAIL stop_keep: tasta %h want 16", tasta); else n_pass++;
    endtask

    task automatic test_timeout;
        int p0, t, d;
        p0 = err_pulse;
        send_frame(8'h4B, 1'b0, 1'b1, 5, t);
        repeat (TO + 60) @(negedge clock);
        d = err_cyc - t;
        n_total++; if (err_pulse !== p0 + 1) $display("FAIL timeout_pulse: got %0d want %0d", err_pulse, p0 + 1); else n_pass++;
        n_total++; if (d < TO || d > TO + FL + 6) $display("FAIL timeout_delay: got %0d want %0d..%0d", d, TO, TO + FL + 6); else n_pass++;
        send_byte(8'h4B);
        n_total++; if (tasta !== 8'h4B || err_pulse !== p0 + 1) $display("FAIL timeout_recover: tasta %h pulses %0d want 4b/%0d", tasta, err_pulse, p0 + 1); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int r0, t1, t2;
        wait_done_low("b2b_pre_low");
        r0 = rise_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, t1);
        send_frame(8'h23, 1'b0, 1'b1, 11, t2);
        n_total++; if (tasta !== 8'h23 || done !== 1'b1) $display("FAIL b2b_tasta: tasta %h done %b want 23/1", tasta, done); else n_pass++;
        wait_done_low("b2b_done_fall");
        n_total++; if (last_len !== (t2 - t1) + DH) $display("FAIL b2b_hold_len: got %0d want %0d", last_len, (t2 - t1) + DH); else n_pass++;
        n_total++; if (rise_cnt !== r0 + 1) $display("FAIL b2b_no_gap: rises %0d want %0d", rise_cnt, r0 + 1); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        int t;
        send_byte(8'hE0);
        send_frame(8'h5A, 1'b0, 1'b1, 5, t);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_total++; if (tasta !== 8'h00 || done !== 1'b0 || ext_key !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL midreset_outputs: tasta %h done %b ext %b err %b want 00/0/0/0", tasta, done, ext_key, frame_err);
        else n_pass++;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        send_byte(8'h5A);
        n_total++; if (tasta !== 8'h5A || done !== 1'b1) $display("FAIL midreset_recover: tasta %h done %b want 5a/1", tasta, done); else n_pass++;
        n_total++; if (ext_key !== 1'b0) $display("FAIL midreset_ext_cleared: got %b want 0", ext_key); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_ext;
        test_errors;
        test_timeout;
        test_back_to_back;
        test_reset_midframe;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
